// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the seg_scan_mux slice
package seg_scan_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
    localparam int DIM_W = 4;

    typedef enum logic [1:0] {
        MODE_OR    = 2'd0,
        MODE_PRIO  = 2'd1,
        MODE_SEL   = 2'd2,
        MODE_BLANK = 2'd3
    } mode_e;

    // Width of a channel selector; a single source still gets one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_compose.sv
// rtl/seg_compose.sv - combinational NUM_CH-to-1 segment merge for one digit
module seg_compose
    import seg_scan_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = 1
) (
    input  logic [NUM_CH*SEG_W-1:0] seg_in,
    input  mode_e                   mode,
    input  logic [SEL_W-1:0]        ch_sel,
    output logic [SEG_W-1:0]        seg_out
);

    logic [SEG_W-1:0] or_seg;
    logic [SEG_W-1:0] prio_seg;
    logic [SEG_W-1:0] sel_seg;

    // Walk from the highest channel down so the lowest nonzero one wins.
    always_comb begin
        or_seg   = SEG_OFF;
        prio_seg = SEG_OFF;
        sel_seg  = SEG_OFF;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            or_seg = or_seg | seg_in[c*SEG_W +: SEG_W];
            if (seg_in[c*SEG_W +: SEG_W] != SEG_OFF) begin
                prio_seg = seg_in[c*SEG_W +: SEG_W];
            end
            if (int'(ch_sel) == c) begin
                sel_seg = seg_in[c*SEG_W +: SEG_W];
            end
        end
    end

    always_comb begin
        seg_out = SEG_OFF;
        case (mode)
            MODE_OR:   seg_out = or_seg;
            MODE_PRIO: seg_out = prio_seg;
            MODE_SEL:  seg_out = sel_seg;
            default:   seg_out = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multi-channel 7-segment scan controller; optional SEG_SCAN_DIM_EN brightness gate
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_CH     = 2,
    parameter int SCAN_DIV   = 4096,
    parameter int BLANK_CYC  = 64,
    localparam int SEL_W     = sel_width(NUM_CH)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_CH*NUM_DIGITS*7-1:0] ch_seg,
    input  logic [1:0]                     mode,
    input  logic [SEL_W-1:0]               ch_sel,
`ifdef SEG_SCAN_DIM_EN
    input  logic [DIM_W-1:0]               brightness,
`endif
    output logic [NUM_DIGITS-1:0]          com,
    output logic [SEG_W-1:0]               Segout,
    output logic                           frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]                       presc_q, presc_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]    buf_q, buf_d;
    logic                                load_pending_q, load_pending_d;
    logic [NUM_DIGITS-1:0]               com_q, com_d;
    logic [SEG_W-1:0]                    segout_q, segout_d;
    logic                                fs_q, fs_d;
    logic [NUM_DIGITS-1:0][SEG_W-1:0]    merged;
    logic                                tick;
    logic                                wrap;
    logic                                load;
    logic                                lit;

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        logic [NUM_CH*SEG_W-1:0] dig_in;
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            assign dig_in[c*SEG_W +: SEG_W] = ch_seg[(c*NUM_DIGITS+d)*SEG_W +: SEG_W];
        end
        seg_compose #(
            .NUM_CH (NUM_CH),
            .SEL_W  (SEL_W)
        ) u_compose (
            .seg_in  (dig_in),
            .mode    (mode_e'(mode)),
            .ch_sel  (ch_sel),
            .seg_out (merged[d])
        );
    end

`ifdef SEG_SCAN_DIM_EN
    logic [DIM_W-1:0] dim_q, dim_d;
    logic [DIM_W-1:0] bright_q, bright_d;

    always_comb begin
        dim_d    = dim_q + 1'b1;
        bright_d = load ? brightness : bright_q;
        lit      = (dim_d < bright_d) || (bright_d == {DIM_W{1'b1}});
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            dim_q    <= '0;
            bright_q <= '0;
        end else begin
            dim_q    <= dim_d;
            bright_q <= bright_d;
        end
    end
`else
    assign lit = 1'b1;
`endif

    // Outputs are computed from next-state values so a digit's common and the
    // index register always change on the same edge.
    always_comb begin
        tick           = (presc_q == PW'(SCAN_DIV - 1));
        wrap           = tick && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d        = tick ? '0 : presc_q + 1'b1;
        idx_d          = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        load           = load_pending_q || wrap;
        load_pending_d = load_pending_q && !load;
        buf_d          = load ? merged : buf_q;
        fs_d           = load;
        com_d          = '1;
        segout_d       = SEG_OFF;
        if ((int'(presc_d) >= BLANK_CYC) && lit) begin
            com_d[idx_d] = 1'b0;
            segout_d     = buf_d[idx_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            presc_q        <= '0;
            idx_q          <= '0;
            buf_q          <= '0;
            load_pending_q <= 1'b1;
            com_q          <= '1;
            segout_q       <= SEG_OFF;
            fs_q           <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            buf_q          <= buf_d;
            load_pending_q <= load_pending_d;
            com_q          <= com_d;
            segout_q       <= segout_d;
            fs_q           <= fs_d;
        end
    end

    assign com         = com_q;
    assign Segout      = segout_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - table-driven bench for seg_scan_mux (8 digits, 2 channels, 4-cycle slots)
module tb_seg_scan_mux;

    localparam int ND = 8;
    localparam int NC = 2;
    localparam int NV = 34;

    typedef struct {
        int         k;
        logic [7:0] com;
        logic [6:0] seg;
        logic       fs;
    } vec_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NC*ND*7-1:0] ch_seg;
    logic [1:0]     mode;
    logic [0:0]     ch_sel;
    logic [3:0]     brightness;
    logic [7:0]     com;
    logic [6:0]     Segout;
    logic           frame_start;

    int   checks   = 0;
    int   failures = 0;
    int   kc       = 0;
    vec_t tbl [NV];

    seg_scan_mux #(
        .NUM_DIGITS (ND),
        .NUM_CH     (NC),
        .SCAN_DIV   (4),
        .BLANK_CYC  (1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ch_seg      (ch_seg),
        .mode        (mode),
        .ch_sel      (ch_sel),
`ifdef SEG_SCAN_DIM_EN
        .brightness  (brightness),
`endif
        .com         (com),
        .Segout      (Segout),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    task automatic set_seg(input int c, input int d, input logic [6:0] v);
        ch_seg[(c*ND+d)*7 +: 7] = v;
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    // Mid-frame input changes, applied just after edge k is sampled.
    task automatic apply_stim(input int k);
        case (k)
            20:  begin mode = 2'd1; set_seg(0, 6, 7'h00); end
            54:  set_seg(0, 5, 7'h01);
            86:  begin mode = 2'd2; ch_sel = 1'b1; end
            109: begin set_seg(1, 2, 7'h55); set_seg(1, 5, 7'h2A); end
            150: mode = 2'd3;
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        kc++;
        apply_stim(kc);
    endtask

    task automatic check_out(input string name, input int k, input logic [7:0] c,
                             input logic [6:0] s, input logic f);
        check({name, "_com"}, k, 32'(com), 32'(c));
        check({name, "_seg"}, k, 32'(Segout), 32'(s));
        check({name, "_fs"}, k, 32'(frame_start), 32'(f));
    endtask

    initial begin
        tbl[0]  = '{1,   8'hFE, 7'h11, 1'b1};
        tbl[1]  = '{2,   8'hFE, 7'h11, 1'b0};
        tbl[2]  = '{3,   8'hFE, 7'h11, 1'b0};
        tbl[3]  = '{4,   8'hFF, 7'h00, 1'b0};
        tbl[4]  = '{5,   8'hFD, 7'h00, 1'b0};
        tbl[5]  = '{8,   8'hFF, 7'h00, 1'b0};
        tbl[6]  = '{9,   8'hFB, 7'h46, 1'b0};
        tbl[7]  = '{11,  8'hFB, 7'h46, 1'b0};
        tbl[8]  = '{12,  8'hFF, 7'h00, 1'b0};
        tbl[9]  = '{21,  8'hDF, 7'h3F, 1'b0};
        tbl[10] = '{25,  8'hBF, 7'h7F, 1'b0};
        tbl[11] = '{28,  8'hFF, 7'h00, 1'b0};
        tbl[12] = '{29,  8'h7F, 7'h00, 1'b0};
        tbl[13] = '{32,  8'hFF, 7'h00, 1'b1};
        tbl[14] = '{33,  8'hFE, 7'h01, 1'b0};
        tbl[15] = '{41,  8'hFB, 7'h06, 1'b0};
        tbl[16] = '{53,  8'hDF, 7'h3F, 1'b0};
        tbl[17] = '{55,  8'hDF, 7'h3F, 1'b0};
        tbl[18] = '{57,  8'hBF, 7'h00, 1'b0};
        tbl[19] = '{64,  8'hFF, 7'h00, 1'b1};
        tbl[20] = '{65,  8'hFE, 7'h01, 1'b0};
        tbl[21] = '{85,  8'hDF, 7'h01, 1'b0};
        tbl[22] = '{86,  8'hDF, 7'h01, 1'b0};
        tbl[23] = '{96,  8'hFF, 7'h00, 1'b1};
        tbl[24] = '{97,  8'hFE, 7'h10, 1'b0};
        tbl[25] = '{105, 8'hFB, 7'h40, 1'b0};
        tbl[26] = '{117, 8'hDF, 7'h3F, 1'b0};
        tbl[27] = '{128, 8'hFF, 7'h00, 1'b1};
        tbl[28] = '{129, 8'hFE, 7'h10, 1'b0};
        tbl[29] = '{137, 8'hFB, 7'h55, 1'b0};
        tbl[30] = '{149, 8'hDF, 7'h2A, 1'b0};
        tbl[31] = '{160, 8'hFF, 7'h00, 1'b1};
        tbl[32] = '{161, 8'hFE, 7'h00, 1'b0};
        tbl[33] = '{185, 8'hBF, 7'h00, 1'b0};

        RST        = 1'b0;
        mode       = 2'd0;
        ch_sel     = 1'b0;
        brightness = 4'hF;
        ch_seg     = '0;
        set_seg(0, 0, 7'h01); set_seg(1, 0, 7'h10);
        set_seg(0, 2, 7'h06); set_seg(1, 2, 7'h40);
        set_seg(0, 5, 7'h00); set_seg(1, 5, 7'h3F);
        set_seg(0, 6, 7'h7F); set_seg(1, 6, 7'h00);

        repeat (3) step();
        check_out("reset", 0, 8'hFF, 7'h00, 1'b0);

        RST = 1'b1;
        kc  = 0;
        for (int i = 0; i < NV; i++) begin
            while (kc < tbl[i].k) step();
            check_out("scan", kc, tbl[i].com, tbl[i].seg, tbl[i].fs);
        end

        // Reset while digit 6 is active, then a fresh OR load from digit 0.
        RST = 1'b0;
        step();
        check_out("rst_mid", kc, 8'hFF, 7'h00, 1'b0);
        step();
        mode = 2'd0;
        RST  = 1'b1;
        kc   = 0;
        step();
        check_out("rel", kc, 8'hFE, 7'h11, 1'b1);
        step();
        check_out("rel", kc, 8'hFE, 7'h11, 1'b0);
        while (kc < 5) step();
        check_out("rel", kc, 8'hFD, 7'h00, 1'b0);
        while (kc < 9) step();
        check_out("rel", kc, 8'hFB, 7'h57, 1'b0);

`ifdef SEG_SCAN_DIM_EN
        for (int b = 0; b < 2; b++) begin
            RST        = 1'b0;
            brightness = (b == 0) ? 4'd4 : 4'd0;
            step();
            step();
            RST = 1'b1;
            kc  = 0;
            for (int j = 1; j <= 32; j++) begin
                logic [7:0] exp_com;
                step();
                exp_com = 8'hFF;
                if ((j % 4) != 0 && (j % 16) < int'(brightness)) begin
                    exp_com[(j / 4) % 8] = 1'b0;
                end
                check("dim_com", j, 32'(com), 32'(exp_com));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
